// File: rtl/prefetch_request_queue.sv
// -----------------------------------------------------------------------------
// prefetch_request_queue
//
// Lower-level cache side of the prefetch request interface. Line prefetch
// requests are filtered against queued and in-flight lines, buffered in a
// FIFO, and issued to memory one at a time with a bounded number of
// outstanding requests. Matching memory responses come back as single-cycle
// fills to the upper level, tagged as prefetched.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   pf_address_i/valid_i  : prefetch request in (byte address)
//   pf_ready_o            : request accepted when pf_valid_i & pf_ready_o
//   demand_address_i/valid_i : demand miss, cancels matching queued lines
//   mem_req_address_o/valid_o, mem_req_ready_i : line-aligned memory request
//   mem_resp_address_i/valid_i : memory response
//   fill_address_o/valid_o/prefetched_o : one-cycle fill to the upper level
//   issued_count_o        : requests sent to memory (saturating)
//   dropped_count_o       : duplicates plus cancelled requests (saturating)
// -----------------------------------------------------------------------------
module prefetch_request_queue #(
    parameter int WIDTH           = 64,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LOGLINE         = 6,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     pf_address_i,
    input  logic                 pf_valid_i,
    output logic                 pf_ready_o,
    input  logic [WIDTH-1:0]     demand_address_i,
    input  logic                 demand_valid_i,
    output logic [WIDTH-1:0]     mem_req_address_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    input  logic [WIDTH-1:0]     mem_resp_address_i,
    input  logic                 mem_resp_valid_i,
    output logic [WIDTH-1:0]     fill_address_o,
    output logic                 fill_valid_o,
    output logic                 fill_prefetched_o,
    output logic [CNT_WIDTH-1:0] issued_count_o,
    output logic [CNT_WIDTH-1:0] dropped_count_o
);

    localparam int LINE_W = WIDTH - LOGLINE;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OST_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic {IDLE, REQ} state_e;

    // Registered state
    state_e                      state_q, state_d;
    logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]              count_q, count_d;
    logic [DEPTH-1:0]            fifo_live_q, fifo_live_d;
    logic [LINE_W-1:0]           fifo_line_q [DEPTH];
    logic [MAX_OUTSTANDING-1:0]  ost_valid_q, ost_valid_d;
    logic [LINE_W-1:0]           ost_line_q [MAX_OUTSTANDING];
    logic [LINE_W-1:0]           req_line_q, req_line_d;
    logic                        fill_valid_q, fill_valid_d;
    logic [LINE_W-1:0]           fill_line_q, fill_line_d;
    logic [CNT_WIDTH-1:0]        issued_q, issued_d, dropped_q, dropped_d;

    // Combinational helpers
    logic [LINE_W-1:0] pf_line, dem_line, resp_line;
    logic              accept, dup, enq, pop, alloc, head_live;
    logic [OST_W-1:0]  alloc_idx;
    logic              alloc_found;
    logic [PTR_W+1:0]  cancel_n, drop_inc;
    logic [CNT_WIDTH:0] drop_sum;

    // Byte offsets inside a line never take part in any comparison.
    logic unused_low_bits;
    assign unused_low_bits = ^{pf_address_i[LOGLINE-1:0],
                               demand_address_i[LOGLINE-1:0],
                               mem_resp_address_i[LOGLINE-1:0]};

    assign pf_line   = pf_address_i[WIDTH-1:LOGLINE];
    assign dem_line  = demand_address_i[WIDTH-1:LOGLINE];
    assign resp_line = mem_resp_address_i[WIDTH-1:LOGLINE];

    // Ready is based on the registered count only, so a same-cycle pop
    // never admits a request into a full FIFO.
    assign pf_ready_o = ~rst & (count_q != FULL_CNT);
    assign accept     = pf_valid_i & pf_ready_o;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        fifo_live_d  = fifo_live_q;
        ost_valid_d  = ost_valid_q;
        req_line_d   = req_line_q;
        fill_valid_d = 1'b0;
        fill_line_d  = fill_line_q;
        issued_d     = issued_q;
        dup          = 1'b0;
        cancel_n     = '0;
        pop          = 1'b0;
        alloc        = 1'b0;
        alloc_idx    = '0;
        alloc_found  = 1'b0;

        // Duplicate filter against the pre-update FIFO and outstanding table.
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_live_q[i] && fifo_line_q[i] == pf_line) dup = 1'b1;
        end
        for (int j = 0; j < MAX_OUTSTANDING; j++) begin
            if (ost_valid_q[j] && ost_line_q[j] == pf_line) dup = 1'b1;
        end
        enq = accept & ~dup;

        // Demand cancel; the head already presented to memory is immune.
        for (int i = 0; i < DEPTH; i++) begin
            if (demand_valid_i && fifo_live_q[i] && fifo_line_q[i] == dem_line &&
                !(state_q == REQ && head_q == PTR_W'(i))) begin
                fifo_live_d[i] = 1'b0;
                cancel_n       = cancel_n + 1'b1;
            end
        end

        // A head cancelled this cycle must not be launched; it is popped next.
        head_live = fifo_live_d[head_q];

        // Lowest free outstanding slot, taken from the pre-update table.
        for (int j = 0; j < MAX_OUTSTANDING; j++) begin
            if (!alloc_found && !ost_valid_q[j]) begin
                alloc_idx   = OST_W'(j);
                alloc_found = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0 && !fifo_live_q[head_q]) begin
                    pop = 1'b1;
                end else if (head_live && alloc_found) begin
                    state_d    = REQ;
                    req_line_d = fifo_line_q[head_q];
                end
            end
            REQ: begin
                if (mem_req_ready_i) begin
                    pop     = 1'b1;
                    alloc   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            fifo_live_d[head_q] = 1'b0;
            head_d              = head_q + 1'b1;
        end
        // Pop needs count > 0 and enqueue needs count < DEPTH, so the two
        // slots touched here are always distinct.
        if (enq) begin
            fifo_live_d[tail_q] = 1'b1;
            tail_d              = tail_q + 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);

        // Response free; a slot freed now is only seen by IDLE next cycle.
        for (int j = 0; j < MAX_OUTSTANDING; j++) begin
            if (mem_resp_valid_i && ost_valid_q[j] && ost_line_q[j] == resp_line) begin
                ost_valid_d[j] = 1'b0;
                fill_valid_d   = 1'b1;
                fill_line_d    = resp_line;
            end
        end
        if (alloc) begin
            ost_valid_d[alloc_idx] = 1'b1;
            if (issued_q != '1) issued_d = issued_q + 1'b1;
        end

        drop_inc  = cancel_n + (PTR_W+2)'(accept & dup);
        drop_sum  = {1'b0, dropped_q} + (CNT_WIDTH+1)'(drop_inc);
        dropped_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fifo_live_q  <= '0;
            ost_valid_q  <= '0;
            req_line_q   <= '0;
            fill_valid_q <= 1'b0;
            fill_line_q  <= '0;
            issued_q     <= '0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fifo_live_q  <= fifo_live_d;
            ost_valid_q  <= ost_valid_d;
            req_line_q   <= req_line_d;
            fill_valid_q <= fill_valid_d;
            fill_line_q  <= fill_line_d;
            issued_q     <= issued_d;
            dropped_q    <= dropped_d;
        end
    end

    // NOTE: line payload storage is not reset; the live/valid bits above
    // qualify every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq)   fifo_line_q[tail_q]   <= pf_line;
        if (alloc) ost_line_q[alloc_idx] <= req_line_q;
    end

    assign mem_req_valid_o   = (state_q == REQ);
    assign mem_req_address_o = {req_line_q, {LOGLINE{1'b0}}};
    assign fill_valid_o      = fill_valid_q;
    assign fill_prefetched_o = fill_valid_q;
    assign fill_address_o    = {fill_line_q, {LOGLINE{1'b0}}};
    assign issued_count_o    = issued_q;
    assign dropped_count_o   = dropped_q;

endmodule

// File: tb/tb_prefetch_request_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_request_queue
//
// Directed stimulus for prefetch_request_queue. Expected memory requests and
// fills are pushed into queues as stimulus is issued; an independent monitor
// compares whatever the DUT presents against the queue heads.
// -----------------------------------------------------------------------------
module tb_prefetch_request_queue;

    localparam int WIDTH           = 64;
    localparam int DEPTH           = 8;
    localparam int MAX_OUTSTANDING = 4;
    localparam int LOGLINE         = 6;
    localparam int CNT_WIDTH       = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     pf_address_i;
    logic                 pf_valid_i;
    logic                 pf_ready_o;
    logic [WIDTH-1:0]     demand_address_i;
    logic                 demand_valid_i;
    logic [WIDTH-1:0]     mem_req_address_o;
    logic                 mem_req_valid_o;
    logic                 mem_req_ready_i;
    logic [WIDTH-1:0]     mem_resp_address_i;
    logic                 mem_resp_valid_i;
    logic [WIDTH-1:0]     fill_address_o;
    logic                 fill_valid_o;
    logic                 fill_prefetched_o;
    logic [CNT_WIDTH-1:0] issued_count_o;
    logic [CNT_WIDTH-1:0] dropped_count_o;

    always #5 clk = ~clk;

    prefetch_request_queue #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .LOGLINE(LOGLINE), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .pf_address_i(pf_address_i), .pf_valid_i(pf_valid_i), .pf_ready_o(pf_ready_o),
        .demand_address_i(demand_address_i), .demand_valid_i(demand_valid_i),
        .mem_req_address_o(mem_req_address_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_address_i(mem_resp_address_i), .mem_resp_valid_i(mem_resp_valid_i),
        .fill_address_o(fill_address_o), .fill_valid_o(fill_valid_o),
        .fill_prefetched_o(fill_prefetched_o),
        .issued_count_o(issued_count_o), .dropped_count_o(dropped_count_o)
    );

    logic [63:0] exp_req[$];
    logic [63:0] exp_fill[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_total++;
        $display("FAIL %s: got 0x%0h, expected no output", name, act);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid_o) begin
                if (exp_req.size() == 0)
                    unexpected("mem_req_unexpected", mem_req_address_o);
                else if (mem_req_ready_i)
                    check("mem_req_addr", mem_req_address_o, exp_req.pop_front());
                else
                    check("mem_req_hold", mem_req_address_o, exp_req[0]);
            end
            if (fill_valid_o) begin
                check("fill_prefetched", 64'(fill_prefetched_o), 64'd1);
                if (exp_fill.size() == 0)
                    unexpected("fill_unexpected", fill_address_o);
                else
                    check("fill_addr", fill_address_o, exp_fill.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pf(input logic [63:0] a);
        pf_address_i = a;
        pf_valid_i   = 1'b1;
        check("pf_ready_on_send", 64'(pf_ready_o), 64'd1);
        tick();
        pf_valid_i = 1'b0;
    endtask

    task automatic demand(input logic [63:0] a);
        demand_address_i = a;
        demand_valid_i   = 1'b1;
        tick();
        demand_valid_i = 1'b0;
    endtask

    task automatic respond(input logic [63:0] a);
        mem_resp_address_i = a;
        mem_resp_valid_i   = 1'b1;
        tick();
        mem_resp_valid_i = 1'b0;
    endtask

    task automatic wait_reqs(input int remaining, input int budget);
        int b = budget;
        while (exp_req.size() > remaining && b > 0) begin
            tick();
            b--;
        end
        check("req_drain", 64'(exp_req.size()), 64'(remaining));
    endtask

    task automatic wait_fills(input int budget);
        int b = budget;
        while (exp_fill.size() > 0 && b > 0) begin
            tick();
            b--;
        end
        check("fill_drain", 64'(exp_fill.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        pf_address_i = '0;       pf_valid_i = 1'b0;
        demand_address_i = '0;   demand_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_address_i = '0; mem_resp_valid_i = 1'b0;
        tick(3);

        // Reset state
        check("rst_pf_ready",      64'(pf_ready_o), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_mem_req_addr",  mem_req_address_o, 64'd0);
        check("rst_fill_valid",    64'(fill_valid_o), 64'd0);
        check("rst_fill_pf",       64'(fill_prefetched_o), 64'd0);
        check("rst_fill_addr",     fill_address_o, 64'd0);
        check("rst_issued",        64'(issued_count_o), 64'd0);
        check("rst_dropped",       64'(dropped_count_o), 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", 64'(pf_ready_o), 64'd1);

        // Single prefetch with latency checks
        mem_req_ready_i = 1'b1;
        exp_req.push_back(64'h1200);
        send_pf(64'h1234);
        check("no_req_at_n_plus_1", 64'(mem_req_valid_o), 64'd0);
        tick();
        check("req_at_n_plus_2", 64'(mem_req_valid_o), 64'd1);
        wait_reqs(0, 20);
        tick(2);
        exp_fill.push_back(64'h1200);
        respond(64'h1200);
        check("fill_at_m_plus_1", 64'(fill_valid_o), 64'd1);
        tick();
        check("fill_one_cycle", 64'(fill_valid_o), 64'd0);
        wait_fills(10);
        check("single_issued",  64'(issued_count_o), 64'd1);
        check("single_dropped", 64'(dropped_count_o), 64'd0);

        // Duplicate filter
        tick(2);
        exp_req.push_back(64'h1200);
        exp_req.push_back(64'h1240);
        send_pf(64'h1200);
        send_pf(64'h1208);
        send_pf(64'h1240);
        wait_reqs(0, 30);
        check("dup_dropped", 64'(dropped_count_o), 64'd1);
        check("dup_issued",  64'(issued_count_o), 64'd3);
        exp_fill.push_back(64'h1200);
        exp_fill.push_back(64'h1240);
        respond(64'h1200);
        respond(64'h1240);
        wait_fills(10);

        // Backpressure, full FIFO, outstanding limit
        tick(2);
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) exp_req.push_back(64'h3000 + 64'(i) * 64'h40);
        for (int i = 0; i < 8; i++) send_pf(64'h3000 + 64'(i) * 64'h40);
        pf_address_i = 64'h3200;
        pf_valid_i   = 1'b1;
        check("full_ready_low", 64'(pf_ready_o), 64'd0);
        tick(3);
        check("full_ready_held", 64'(pf_ready_o), 64'd0);
        pf_valid_i = 1'b0;
        check("full_not_dropped", 64'(dropped_count_o), 64'd1);
        check("stalled_req_valid", 64'(mem_req_valid_o), 64'd1);
        mem_req_ready_i = 1'b1;
        wait_reqs(4, 40);
        tick(8);
        check("ost_full_stall",  64'(mem_req_valid_o), 64'd0);
        check("ost_full_issued", 64'(issued_count_o), 64'd7);
        check("ost_full_ready",  64'(pf_ready_o), 64'd1);
        exp_fill.push_back(64'h3040); respond(64'h3040); wait_reqs(3, 20);
        exp_fill.push_back(64'h3000); respond(64'h3000); wait_reqs(2, 20);
        exp_fill.push_back(64'h3080); respond(64'h3080); wait_reqs(1, 20);
        exp_fill.push_back(64'h30c0); respond(64'h30c0); wait_reqs(0, 20);
        tick(2);
        for (int i = 4; i < 8; i++) begin
            exp_fill.push_back(64'h3000 + 64'(i) * 64'h40);
            respond(64'h3000 + 64'(i) * 64'h40);
        end
        wait_fills(10);
        check("bp_issued", 64'(issued_count_o), 64'd11);

        // Demand cancel
        tick(2);
        mem_req_ready_i = 1'b0;
        exp_req.push_back(64'h2000);
        exp_req.push_back(64'h2080);
        send_pf(64'h2000);
        send_pf(64'h2040);
        send_pf(64'h2080);
        tick(2);
        check("cancel_head_in_req", 64'(mem_req_valid_o), 64'd1);
        demand(64'h2040);
        demand(64'h2000);
        tick();
        check("cancel_dropped", 64'(dropped_count_o), 64'd2);
        mem_req_ready_i = 1'b1;
        wait_reqs(0, 30);
        tick(4);
        check("cancel_issued",  64'(issued_count_o), 64'd13);
        check("head_not_cancelled", 64'(dropped_count_o), 64'd2);
        send_pf(64'h2010);
        tick(4);
        check("dup_outstanding_dropped", 64'(dropped_count_o), 64'd3);
        check("dup_outstanding_issued",  64'(issued_count_o), 64'd13);
        exp_fill.push_back(64'h2000);
        exp_fill.push_back(64'h2080);
        respond(64'h2000);
        respond(64'h2080);
        wait_fills(10);

        // Unmatched response
        tick(2);
        respond(64'h9000);
        check("unmatched_no_fill", 64'(fill_valid_o), 64'd0);
        tick(3);

        // Reset with two requests outstanding, then late responses
        exp_req.push_back(64'h5000);
        exp_req.push_back(64'h5040);
        send_pf(64'h5000);
        send_pf(64'h5040);
        wait_reqs(0, 30);
        tick(2);
        rst = 1'b1;
        tick();
        check("mid_rst_pf_ready", 64'(pf_ready_o), 64'd0);
        check("mid_rst_issued",   64'(issued_count_o), 64'd0);
        tick();
        rst = 1'b0;
        respond(64'h5000);
        check("late_resp0_no_fill", 64'(fill_valid_o), 64'd0);
        respond(64'h5040);
        check("late_resp1_no_fill", 64'(fill_valid_o), 64'd0);
        tick(2);
        check("post_rst_issued",    64'(issued_count_o), 64'd0);
        check("post_rst_dropped",   64'(dropped_count_o), 64'd0);
        check("post_rst_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("post_rst_req_addr",  mem_req_address_o, 64'd0);
        check("post_rst_fill_addr", fill_address_o, 64'd0);
        check("post_rst_fill_valid", 64'(fill_valid_o), 64'd0);

        tick(5);
        check("end_req_queue_empty",  64'(exp_req.size()), 64'd0);
        check("end_fill_queue_empty", 64'(exp_fill.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prefetch_request_queue.md
# prefetch_request_queue

Lower-level cache side of the prefetch request interface. Accepts line prefetch requests from the best-offset prefetcher. Drops duplicates and requests cancelled by demand traffic, buffers the rest in a FIFO, and issues them to memory under a bounded-outstanding handshake. Returns completed fills to the upper level with the prefetched bit set, which feeds the prefetcher's `up_prefetched_i`.

## Interface
- `WIDTH`, 64, address width in bits.
- `DEPTH`, 8, request FIFO entries (power of two, ≥2).
- `MAX_OUTSTANDING`, 4, in-flight memory requests (≥1).
- `LOGLINE`, 6, log2 of line size in bytes.
- `CNT_WIDTH`, 16, statistics counter width.

Ports:
- `clk`, in, 1, clock. One clock domain.
- `rst`, in, 1, reset. Synchronous, active-high.
- `pf_address_i`, in, WIDTH, prefetch byte address.
- `pf_valid_i`, in, 1, prefetch request valid.
- `pf_ready_o`, out, 1, request accepted when `pf_valid_i & pf_ready_o`.
- `demand_address_i`, in, WIDTH, demand miss address at this level.
- `demand_valid_i`, in, 1, demand miss valid. Used to cancel queued prefetches.
- `mem_req_address_o`, out, WIDTH, line-aligned memory request address.
- `mem_req_valid_o`, out, 1, memory request valid.
- `mem_req_ready_i`, in, 1, memory accepts the request.
- `mem_resp_address_i`, in, WIDTH, response address.
- `mem_resp_valid_i`, in, 1, response valid.
- `fill_address_o`, out, WIDTH, line-aligned fill address to the upper level.
- `fill_valid_o`, out, 1, fill valid. Single-cycle pulse.
- `fill_prefetched_o`, out, 1, high whenever `fill_valid_o` is high.
- `issued_count_o`, out, CNT_WIDTH, requests sent to memory. Saturating.
- `dropped_count_o`, out, CNT_WIDTH, requests dropped or cancelled. Saturating.

## Operation
- Line address = `addr >> LOGLINE`. All comparisons use line addresses. Emitted addresses have the low `LOGLINE` bits zero.
- **FIFO:** entry holds {line, live}. Head/tail pointers are `log2(DEPTH)` bits with wrap-around. `count` runs 0..DEPTH.
- **Ready:** `pf_ready_o = ~rst & (count != DEPTH)`. Based on registered count, so a pop in the same cycle does not admit a request when full.
- **Accept filter:** on accept, compare against the pre-update state.
  - Line matches a live FIFO entry or a valid outstanding entry: not enqueued, `dropped_count` +1.
  - Otherwise: enqueue with live=1.
- **Demand cancel:** if `demand_valid_i` and the demand line matches any live FIFO entry, clear live on that entry, `dropped_count` +1 per cleared entry.
  - The head entry currently presented in state REQ is not cancelled.
  - If demand and accept hit the same line in the same cycle, the new entry is still enqueued live.
- **Issue FSM, states IDLE and REQ:**
  - IDLE, head not live and count > 0: pop the head, no issue.
  - IDLE, head live and outstanding < MAX_OUTSTANDING: go to REQ and latch the head line into `mem_req_address_o`.
  - REQ: `mem_req_valid_o = 1`. Address is held stable until `mem_req_ready_i`.
  - REQ on handshake: pop the head, allocate an outstanding slot (lowest free index), `issued_count` +1, return to IDLE.
  - At most one issue per 2 cycles.
- **Outstanding table:** `MAX_OUTSTANDING` entries of {valid, line}.
  - On `mem_resp_valid_i`: the matching valid entry is freed. Next cycle, `fill_valid_o = fill_prefetched_o = 1` with the line address.
  - A response with no match is ignored: no fill, no state change.
  - Response free and handshake allocate in the same cycle are both performed. The freed slot is not visible to the IDLE check until the next cycle.
- Counters saturate at all-ones.

## Timing
- **Reset values:** every output is 0 (`pf_ready_o` is 0 while `rst` is high). FIFO empty, table empty, FSM in IDLE, counters 0. Reset mid-transaction discards all state; a subsequent late response is unmatched and ignored.
- **Accept to request:** request accepted at edge N gives `mem_req_valid_o` high in cycle N+2 at the earliest (N+1: IDLE sees head, N+2: REQ).
- **Response to fill:** response at edge M gives `fill_valid_o` high in cycle M+1, for exactly one cycle.
- **Full FIFO:** `pf_ready_o` = 0 and the request is not consumed. Upstream holds or abandons it; this block does not count it as dropped.
- **Outstanding full:** FSM stays in IDLE with the head live, and the FIFO backs up.

## Test plan
- **Single prefetch.** `pf_address_i=0x1234` valid 1 cycle, `mem_req_ready_i=1` → `mem_req_address_o=0x1200` valid for 1 cycle. Then response 0x1200 → next cycle `fill_valid_o=1`, `fill_prefetched_o=1`, `fill_address_o=0x1200`. `issued_count_o=1`.
- **Duplicate filter.** Send 0x1200, 0x1208, 0x1240 back-to-back → 2 memory requests (0x1200, 0x1240). `dropped_count_o=1`.
- **Backpressure/full.** `mem_req_ready_i=0`, send 9 distinct lines with DEPTH=8 → 8 accepted, `pf_ready_o=0` on the 9th. `mem_req_address_o` stays stable throughout. Release ready → 4 issue, then the FSM stalls at MAX_OUTSTANDING=4 until a response frees a slot.
- **Demand cancel.** Queue 0x2000, 0x2040, 0x2080 while the head is stalled in REQ. Demand 0x2040 → issued order is 0x2000 then 0x2080. `dropped_count_o=1`. Demand on the REQ head line → no cancel.
- **Unmatched response and reset.** Response 0x9000 with nothing outstanding → no fill. Assert `rst` with 2 outstanding, then deliver their responses → no fills, all outputs 0, counters 0.
